// File: rtl/ins_fetch_q_pkg.sv
// Shared constants for the fetch queue: opcodes, RVC quadrant patterns, FSM states
// and immediate extraction helpers (32-bit instruction encodings).
package ins_fetch_q_pkg;

    localparam int DAT_W = 32;

    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;

    // {ins[15:13], ins[1:0]} patterns for compressed control flow
    localparam logic [4:0] CJ    = 5'b10101;
    localparam logic [4:0] CJAL  = 5'b00101;
    localparam logic [4:0] CBEQZ = 5'b11001;
    localparam logic [4:0] CBNEZ = 5'b11101;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } fetch_st_e;

    function automatic logic signed [31:0] imm_j(input logic [31:0] i);
        return 32'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] i);
        return 32'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    endfunction

    function automatic logic signed [31:0] imm_cj(input logic [31:0] i);
        return 32'(signed'({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0}));
    endfunction

    function automatic logic signed [31:0] imm_cb(input logic [31:0] i);
        return 32'(signed'({i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0}));
    endfunction

endpackage

// File: rtl/ins_fetch_q_fifo.sv
// Generic DEPTH x W FIFO with push/pop/flush and occupancy count.
// Caller must not push when full; flush wins over push/pop.
module ins_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 66
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // power-of-two depth: pointers wrap naturally
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/ins_fetch_q.sv
// Fetch unit: next-PC prediction, icache miss handshake, QDEPTH-deep instruction queue.
// Define INS_FETCH_RVC_EN to enable compressed-instruction detection and C jump/branch targets.
module ins_fetch_q
    import ins_fetch_q_pkg::*;
#(
    parameter int              XLEN     = DAT_W,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      ic_en_i,
    input  logic [XLEN-1:0]           ic_ins_i,
    output logic                      ic_en_o,
    output logic [XLEN-1:0]           ic_pc_o,
    output logic [XLEN-1:0]           bp_pc_o,
    input  logic                      bp_br_i,
    input  logic                      br_flag_i,
    input  logic [XLEN-1:0]           br_cbt_i,
    output logic                      is_valid_o,
    input  logic                      is_ready_i,
    output logic [XLEN-1:0]           is_ins_o,
    output logic [XLEN-1:0]           is_pc_o,
    output logic                      is_ic_o,
    output logic                      is_pbr_o,
    output logic [$clog2(QDEPTH):0]   q_cnt_o
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = 2 * XLEN + 2;

    fetch_st_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            ic_en_q, ic_en_d;

    logic [CW-1:0]   cnt;
    logic [EW-1:0]   enq_ent, head_ent;
    logic            full, enq, deq, flush;
    logic [31:0]     ins;
    logic            is_c, is_jal, is_br, is_cj, is_cb, pbr;
    logic [XLEN-1:0] npc;

    assign ins = ic_ins_i[31:0];

`ifdef INS_FETCH_RVC_EN
    logic [4:0] cq;
    assign cq     = {ins[15:13], ins[1:0]};
    assign is_c   = (ins[1:0] != 2'b11);
    assign is_jal = (ins[6:0] == OPC_JAL);
    assign is_br  = (ins[6:0] == OPC_BR);
    assign is_cj  = (cq == CJ) || (cq == CJAL);
    assign is_cb  = (cq == CBEQZ) || (cq == CBNEZ);
`else
    // everything is 32-bit; the length bits are not decoded
    assign is_c   = 1'b0;
    assign is_jal = (ins[6:2] == OPC_JAL[6:2]);
    assign is_br  = (ins[6:2] == OPC_BR[6:2]);
    assign is_cj  = 1'b0;
    assign is_cb  = 1'b0;
`endif

    assign pbr = bp_br_i && (is_br || is_cb);

    always_comb begin
        npc = pc_q + (is_c ? XLEN'(2) : XLEN'(4));
        if (is_jal)              npc = pc_q + XLEN'(imm_j(ins));
        else if (is_br && bp_br_i) npc = pc_q + XLEN'(imm_b(ins));
        else if (is_cj)          npc = pc_q + XLEN'(imm_cj(ins));
        else if (is_cb && bp_br_i) npc = pc_q + XLEN'(imm_cb(ins));
    end

    assign full       = (cnt == CW'(QDEPTH));
    assign is_valid_o = (cnt != '0) && !br_flag_i;
    assign flush      = en && br_flag_i;
    assign deq        = en && is_valid_o && is_ready_i;
    // fullness is judged before this cycle's dequeue: no bypass into a full queue
    assign enq        = en && !br_flag_i && (state_q == ST_FETCH) && !full && ic_en_i;
    assign enq_ent    = {ic_ins_i, pc_q, is_c, pbr};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ic_en_d = ic_en_q;
        if (en) begin
            if (br_flag_i) begin
                pc_d    = br_cbt_i;
                state_d = ST_FETCH;
                ic_en_d = 1'b0;
            end else begin
                case (state_q)
                    ST_FETCH: begin
                        if (full) begin
                            ic_en_d = 1'b0;
                        end else if (ic_en_i) begin
                            pc_d = npc;
                        end else begin
                            state_d = ST_WAIT;
                            ic_en_d = 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (ic_en_i) begin
                            state_d = ST_FETCH;
                            ic_en_d = 1'b0;
                        end
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ic_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ic_en_q <= ic_en_d;
        end
    end

    ins_fifo #(.DEPTH(QDEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (enq),
        .pop   (deq),
        .din   (enq_ent),
        .dout  (head_ent),
        .cnt   (cnt)
    );

    assign {is_ins_o, is_pc_o, is_ic_o, is_pbr_o} = head_ent;
    assign ic_en_o = ic_en_q;
    assign ic_pc_o = pc_q;
    assign bp_pc_o = pc_q;
    assign q_cnt_o = cnt;

endmodule

// File: tb/tb_ins_fetch_q.sv
// Table-driven bench for ins_fetch_q with a scoreboard of expected queue entries.
module tb_ins_fetch_q;
    logic        clk = 0;
    logic        rst = 1;
    logic        en = 0;
    logic        ic_en_i = 0;
    logic [31:0] ic_ins_i = '0;
    logic        ic_en_o;
    logic [31:0] ic_pc_o, bp_pc_o;
    logic        bp_br_i = 0;
    logic        br_flag_i = 0;
    logic [31:0] br_cbt_i = '0;
    logic        is_valid_o;
    logic        is_ready_i = 0;
    logic [31:0] is_ins_o, is_pc_o;
    logic        is_ic_o, is_pbr_o;
    logic [2:0]  q_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ins_fetch_q dut (
        .clk(clk), .rst(rst), .en(en),
        .ic_en_i(ic_en_i), .ic_ins_i(ic_ins_i), .ic_en_o(ic_en_o), .ic_pc_o(ic_pc_o),
        .bp_pc_o(bp_pc_o), .bp_br_i(bp_br_i),
        .br_flag_i(br_flag_i), .br_cbt_i(br_cbt_i),
        .is_valid_o(is_valid_o), .is_ready_i(is_ready_i), .is_ins_o(is_ins_o),
        .is_pc_o(is_pc_o), .is_ic_o(is_ic_o), .is_pbr_o(is_pbr_o), .q_cnt_o(q_cnt_o)
    );

    typedef struct {
        logic        en, br;
        logic [31:0] cbt;
        logic        hit;
        logic [31:0] ins;
        logic        bp, rdy;
        logic [31:0] pc;      // expected fetch PC before the edge
        logic        push, ic, pbr;
        logic        vld;     // expected is_valid_o before the edge
        logic [31:0] npc;     // expected fetch PC after the edge
        logic [2:0]  cnt;
        logic        icen;
    } vec_t;

    typedef struct {
        logic [31:0] ins, pc;
        logic        ic, pbr;
    } ent_t;

    ent_t sb[$];
    vec_t tv[32];

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] JAL = 32'h0400006F;  // jal x0, +0x40
    localparam logic [31:0] BEQ = 32'h00000863;  // beq x0, x0, +16
    localparam logic [31:0] CNOP = 32'h00000001;

    function automatic vec_t mk(input logic e, b, input logic [31:0] cbt, input logic hit,
                                input logic [31:0] ins, input logic bp, rdy,
                                input logic [31:0] pc, input logic push, ic, pbr, vld,
                                input logic [31:0] npc, input logic [2:0] cnt, input logic icen);
        vec_t v;
        v.en = e; v.br = b; v.cbt = cbt; v.hit = hit; v.ins = ins; v.bp = bp; v.rdy = rdy;
        v.pc = pc; v.push = push; v.ic = ic; v.pbr = pbr; v.vld = vld;
        v.npc = npc; v.cnt = cnt; v.icen = icen;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        ent_t e;
        @(negedge clk);
        en = v.en; br_flag_i = v.br; br_cbt_i = v.cbt; ic_en_i = v.hit;
        ic_ins_i = v.ins; bp_br_i = v.bp; is_ready_i = v.rdy;
        #1;
        chk("ic_pc_pre", idx, ic_pc_o, v.pc);
        chk("bp_pc", idx, bp_pc_o, v.pc);
        chk("is_valid", idx, 32'(is_valid_o), 32'(v.vld));
        if (v.en && v.br) sb.delete();
        if (v.push) begin
            e.ins = v.ins; e.pc = v.pc; e.ic = v.ic; e.pbr = v.pbr;
            sb.push_back(e);
        end
        if (v.en && !v.br && v.vld && v.rdy) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL scoreboard [vec %0d]: dequeue with no expected entry", idx);
            end else begin
                e = sb.pop_front();
                chk("head_ins", idx, is_ins_o, e.ins);
                chk("head_pc", idx, is_pc_o, e.pc);
                chk("head_ic", idx, 32'(is_ic_o), 32'(e.ic));
                chk("head_pbr", idx, 32'(is_pbr_o), 32'(e.pbr));
            end
        end
        @(posedge clk);
        #1;
        chk("ic_pc_post", idx, ic_pc_o, v.npc);
        chk("q_cnt", idx, 32'(q_cnt_o), 32'(v.cnt));
        chk("ic_en_o", idx, 32'(ic_en_o), 32'(v.icen));
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_ic_pc", idx, ic_pc_o, 32'h0);
        chk("rst_q_cnt", idx, 32'(q_cnt_o), 32'h0);
        chk("rst_valid", idx, 32'(is_valid_o), 32'h0);
        chk("rst_ic_en", idx, 32'(ic_en_o), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p_bx;  // PC after the BEQ
        logic [31:0] p_c1;  // PC after the C.NOP slot
        logic        c_ic;
`ifdef INS_FETCH_RVC_EN
        p_c1 = 32'h202; p_bx = 32'h212; c_ic = 1'b1;
`else
        p_c1 = 32'h204; p_bx = 32'h214; c_ic = 1'b0;
`endif
        //          en br cbt           hit ins  bp rdy pc            push ic pbr vld npc           cnt icen
        tv[0]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h0,        1,   0, 0,  0,  32'h4,        1,  0);
        tv[1]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h4,        1,   0, 0,  1,  32'h8,        2,  0);
        tv[2]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h8,        1,   0, 0,  1,  32'hC,        3,  0);
        tv[3]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'hC,        1,   0, 0,  1,  32'h10,       4,  0);
        tv[4]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h10,       0,   0, 0,  1,  32'h10,       4,  0);
        tv[5]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h10,       0,   0, 0,  1,  32'h10,       4,  0);
        tv[6]  = mk(1, 0, 0,            1,  NOP, 0, 1,  32'h10,       0,   0, 0,  1,  32'h10,       3,  0);
        tv[7]  = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h10,       1,   0, 0,  1,  32'h14,       4,  0);
        tv[8]  = mk(1, 0, 0,            1,  NOP, 0, 1,  32'h14,       0,   0, 0,  1,  32'h14,       3,  0);
        tv[9]  = mk(1, 1, 32'h80,       1,  NOP, 0, 1,  32'h14,       0,   0, 0,  0,  32'h80,       0,  0);
        tv[10] = mk(1, 1, 32'h100,      0,  NOP, 0, 0,  32'h80,       0,   0, 0,  0,  32'h100,      0,  0);
        tv[11] = mk(1, 0, 0,            1,  JAL, 1, 0,  32'h100,      1,   0, 0,  0,  32'h140,      1,  0);
        tv[12] = mk(1, 0, 0,            1,  NOP, 0, 1,  32'h140,      1,   0, 0,  1,  32'h144,      1,  0);
        tv[13] = mk(1, 1, 32'h200,      0,  NOP, 0, 1,  32'h144,      0,   0, 0,  0,  32'h200,      0,  0);
        tv[14] = mk(1, 0, 0,            1,  CNOP,0, 0,  32'h200,      1,   c_ic,0, 0, p_c1,         1,  0);
        tv[15] = mk(1, 0, 0,            1,  BEQ, 1, 0,  p_c1,         1,   0, 1,  1,  p_bx,         2,  0);
        tv[16] = mk(1, 0, 0,            0,  NOP, 0, 1,  p_bx,         0,   0, 0,  1,  p_bx,         1,  1);
        tv[17] = mk(1, 0, 0,            0,  NOP, 0, 1,  p_bx,         0,   0, 0,  1,  p_bx,         0,  1);
        tv[18] = mk(1, 1, 32'h300,      0,  NOP, 0, 0,  p_bx,         0,   0, 0,  0,  32'h300,      0,  0);
        tv[19] = mk(1, 0, 0,            0,  NOP, 0, 0,  32'h300,      0,   0, 0,  0,  32'h300,      0,  1);
        tv[20] = mk(1, 0, 0,            0,  NOP, 0, 0,  32'h300,      0,   0, 0,  0,  32'h300,      0,  1);
        tv[21] = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h300,      0,   0, 0,  0,  32'h300,      0,  0);
        tv[22] = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h300,      1,   0, 0,  0,  32'h304,      1,  0);
        tv[23] = mk(1, 0, 0,            0,  NOP, 0, 1,  32'h304,      0,   0, 0,  1,  32'h304,      0,  1);
        tv[24] = mk(0, 0, 0,            1,  NOP, 0, 1,  32'h304,      0,   0, 0,  0,  32'h304,      0,  1);
        tv[25] = mk(0, 1, 32'h500,      0,  NOP, 0, 0,  32'h304,      0,   0, 0,  0,  32'h304,      0,  1);
        tv[26] = mk(1, 1, 32'hFFFFFFFC, 0,  NOP, 0, 0,  32'h304,      0,   0, 0,  0,  32'hFFFFFFFC, 0,  0);
        tv[27] = mk(1, 0, 0,            1,  NOP, 0, 0,  32'hFFFFFFFC, 1,   0, 0,  0,  32'h0,        1,  0);
        tv[28] = mk(1, 0, 0,            1,  NOP, 0, 1,  32'h0,        1,   0, 0,  1,  32'h4,        1,  0);
        tv[29] = mk(1, 0, 0,            0,  NOP, 0, 1,  32'h4,        0,   0, 0,  1,  32'h4,        0,  1);
        // after a reset asserted in the middle of WAIT
        tv[30] = mk(1, 0, 0,            1,  NOP, 0, 0,  32'h0,        1,   0, 0,  0,  32'h4,        1,  0);
        tv[31] = mk(1, 0, 0,            1,  BEQ, 0, 1,  32'h4,        1,   0, 0,  1,  32'h8,        1,  0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk_reset(-1);

        for (int i = 0; i < 30; i++) apply(tv[i], i);

        // asynchronous reset mid-WAIT with an icache response arriving
        #2;
        ic_en_i = 1;
        rst = 1;
        #1;
        chk_reset(-2);
        @(negedge clk);
        en = 0;
        rst = 0;
        sb.delete();
        #1;
        chk_reset(-3);

        for (int i = 30; i < 32; i++) apply(tv[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
